// File: rtl/alu_stage_pkg.sv
// Shared widths, opcode encodings, FSM states and operand payload for the
// accumulator execute stage.
package alu_stage_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned OPW   = 3;
  localparam int unsigned CNTW  = 2;

  localparam logic [OPW-1:0] OP_PASS = 3'd0;
  localparam logic [OPW-1:0] OP_ADD  = 3'd1;
  localparam logic [OPW-1:0] OP_SUB  = 3'd2;
  localparam logic [OPW-1:0] OP_NAND = 3'd3;
  localparam logic [OPW-1:0] OP_ADC  = 3'd4;
  localparam logic [OPW-1:0] OP_AND  = 3'd5;
  localparam logic [OPW-1:0] OP_CMP  = 3'd6;
  localparam logic [OPW-1:0] OP_ROL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ROT  = 2'd2
  } state_e;

  // Operands latched at accept; the in-flight op never sees later input changes.
  typedef struct packed {
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

endpackage

// File: rtl/alu_stage_core.sv
// Combinational ALU: operands, carry-in and opcode to result, carry and zero.
// Sequencing of multi-cycle rotates lives in alu_stage, not here.
module alu_core
  import alu_stage_pkg::*;
(
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] r_c,
  output logic             carry_c,
  output logic             carry_we_c,
  output logic             zero_c
);

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff      = b;
    cin        = 1'b0;
    sum        = '0;
    r_c        = '0;
    carry_c    = carry_in;
    carry_we_c = 1'b0;

    // SUB/CMP share the adder as A + ~B + 1; ADC feeds the stored carry in.
    unique case (opcode)
      OP_SUB, OP_CMP: begin b_eff = ~b; cin = 1'b1; end
      OP_ADC:         cin = carry_in;
      default:        ;
    endcase

    sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

    unique case (opcode)
      OP_PASS: r_c = b;
      OP_ADD, OP_SUB, OP_ADC, OP_CMP: begin
        r_c        = sum[WIDTH-1:0];
        carry_c    = sum[WIDTH];
        carry_we_c = 1'b1;
      end
      OP_NAND: r_c = ~(a & b);
      OP_AND:  r_c = a & b;
      OP_ROL:  r_c = a;
      default: r_c = '0;
    endcase
  end

  assign zero_c = (r_c == '0);

endmodule

// File: rtl/alu_stage.sv
// Execute stage feeding the 4-bit accumulator: accepts one op, produces a
// registered result with carry/zero flags and a one-cycle load strobe.
module alu_stage
  import alu_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             flag_c,
  output logic             flag_z,
  output logic             busy
);

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             res_valid_q, res_valid_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             op_ready_q, op_ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] core_r_c;
  logic             core_carry_c;
  logic             core_carry_we_c;
  logic             core_zero_c;

  alu_core u_core (
    .opcode     (op_q.opcode),
    .a          (op_q.a),
    .b          (op_q.b),
    .carry_in   (flag_c_q),
    .r_c        (core_r_c),
    .carry_c    (core_carry_c),
    .carry_we_c (core_carry_we_c),
    .zero_c     (core_zero_c)
  );

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready_q) begin
          op_d = '{opcode: opcode, a: acc_in, b: bus_in};
          if (opcode == OP_ROL && bus_in[CNTW-1:0] != '0) begin
            cnt_d   = bus_in[CNTW-1:0];
            work_d  = acc_in;
            state_d = ST_ROT;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        // CMP only touches flags; result and strobe stay quiet.
        if (op_q.opcode != OP_CMP) begin
          result_d    = core_r_c;
          res_valid_d = 1'b1;
        end
        if (core_carry_we_c) flag_c_d = core_carry_c;
        flag_z_d = core_zero_c;
        state_d  = ST_IDLE;
      end

      ST_ROT: begin
        if (cnt_q != '0) begin
          work_d = rol1(work_q);
          cnt_d  = cnt_q - CNTW'(1);
        end else begin
          result_d    = work_q;
          flag_z_d    = (work_q == '0);
          res_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    op_ready_d = (state_d == ST_IDLE);
    busy_d     = ~op_ready_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      work_q      <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      op_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign op_ready  = op_ready_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: reference model pushes expected results to a
// queue at accept; a negedge monitor pops and compares on each res_valid.
module tb_alu_stage;

  localparam logic [2:0] T_PASS = 3'd0, T_ADD = 3'd1, T_SUB = 3'd2, T_NAND = 3'd3,
                         T_ADC  = 3'd4, T_AND = 3'd5, T_CMP = 3'd6, T_ROL  = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] opcode = '0;
  logic [3:0] acc_in = '0;
  logic [3:0] bus_in = '0;
  logic [3:0] result;
  logic       res_valid;
  logic       flag_c;
  logic       flag_z;
  logic       busy;

  alu_stage dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .acc_in(acc_in), .bus_in(bus_in), .result(result),
    .res_valid(res_valid), .flag_c(flag_c), .flag_z(flag_z), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic       c;
    logic       z;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_rv = 1'b0;

  // model state
  logic       m_c = 1'b0;
  logic [3:0] m_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: one-cycle strobe, ordering, latency and values.
  always @(negedge clk) begin
    if (res_valid) begin
      chk("rv_single_cycle", 32'(prev_rv), 32'(0));
      chk("rv_expected", 32'(sb.size() > 0), 32'(1));
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(e.due));
        chk("result", 32'(result), 32'(e.r));
        chk("flag_c", 32'(flag_c), 32'(e.c));
        chk("flag_z", 32'(flag_z), 32'(e.z));
      end
    end
    prev_rv <= res_valid;
  end

  // Independent reference: returns expected result/carry and updates model.
  task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] r, output logic c, output logic z);
    logic [4:0] s;
    logic [3:0] nb;
    r  = m_r;
    c  = m_c;
    nb = ~b;
    case (op)
      T_PASS: r = b;
      T_ADD:  begin s = {1'b0, a} + {1'b0, b};            r = s[3:0]; c = s[4]; end
      T_SUB:  begin s = {1'b0, a} + {1'b0, nb} + 5'd1;    r = s[3:0]; c = s[4]; end
      T_NAND: r = ~(a & b);
      T_ADC:  begin s = {1'b0, a} + {1'b0, b} + {4'd0, m_c}; r = s[3:0]; c = s[4]; end
      T_AND:  r = a & b;
      T_CMP:  begin s = {1'b0, a} + {1'b0, nb} + 5'd1;    r = s[3:0]; c = s[4]; end
      default: begin
        r = a;
        for (int i = 0; i < int'(b[1:0]); i++) r = {r[2:0], r[3]};
      end
    endcase
    z   = (r == 4'd0);
    m_c = c;
    if (op != T_CMP) m_r = r;
  endtask

  // Present an op, wait (bounded) for accept, push expectation.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic [3:0] r;
    logic c, z;
    bit acc = 0;
    @(negedge clk);
    op_valid = 1'b1; opcode = op; acc_in = a; bus_in = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (op_ready) begin
        @(posedge clk);
        acc = 1;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept_timeout", 32'(acc), 32'(1));
    #1;
    model(op, a, b, r, c, z);
    if (op != T_CMP) begin
      e.r = r; e.c = c; e.z = z;
      e.due = cyc + 1 + ((op == T_ROL) ? int'(b[1:0]) : 0);
      sb.push_back(e);
    end
    op_valid = 1'b0;
    acc_in   = 4'($urandom);
    bus_in   = 4'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (op_ready) ok = 1;
    end
    chk("idle_timeout", 32'(ok), 32'(1));
  endtask

  int busy_cnt;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_flag_c", 32'(flag_c), 32'(0));
    chk("rst_flag_z", 32'(flag_z), 32'(0));
    chk("rst_op_ready", 32'(op_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b1;

    issue(T_ADD, 4'd9, 4'd8);   // 1, C=1
    wait_idle();
    issue(T_SUB, 4'd5, 4'd5);   // 0, C=1, Z=1
    issue(T_ADC, 4'd2, 4'd3);   // back-to-back: 6, C=0
    wait_idle();

    issue(T_CMP, 4'd3, 4'd7);   // C=0 Z=0, result unchanged
    wait_idle();
    chk("cmp1_flag_c", 32'(flag_c), 32'(0));
    chk("cmp1_flag_z", 32'(flag_z), 32'(0));
    chk("cmp1_result", 32'(result), 32'(6));
    issue(T_CMP, 4'd7, 4'd3);   // C=1 Z=0
    wait_idle();
    chk("cmp2_flag_c", 32'(flag_c), 32'(1));
    chk("cmp2_result", 32'(result), 32'(6));
    issue(T_CMP, 4'd4, 4'd4);   // C=1 Z=1
    wait_idle();
    chk("cmp3_flag_z", 32'(flag_z), 32'(1));

    // ROL by 3 with a competing op held while busy
    issue(T_ROL, 4'b1001, 4'd3);
    @(negedge clk);
    op_valid = 1'b1; opcode = T_ADD; acc_in = 4'd1; bus_in = 4'd1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (op_ready) break;
      chk("busy_is_not_ready", 32'(busy), 32'(1));
      busy_cnt++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("rol3_busy_cycles", 32'(busy_cnt), 32'(4));
    repeat (3) @(negedge clk);
    chk("rol3_result_held", 32'(result), 32'b1100);

    issue(T_PASS, 4'd7, 4'd0);  // 0, Z=1, C kept
    issue(T_NAND, 4'hF, 4'hF);  // 0, Z=1, C kept
    issue(T_AND, 4'hC, 4'hA);   // 8
    issue(T_ROL, 4'd5, 4'd4);   // rotate by 0 -> 5, single-cycle
    issue(T_ROL, 4'd1, 4'd1);   // 2
    issue(T_SUB, 4'd2, 4'd3);   // F, C=0 (borrow)
    issue(T_ADC, 4'd7, 4'd8);   // F, C=0
    issue(T_ADD, 4'hF, 4'd1);   // 0, C=1, Z=1
    issue(T_ROL, 4'b0110, 4'd2);// 1001
    wait_idle();

    // reset in the middle of a rotate
    issue(T_ROL, 4'b1001, 4'd3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'(0));
    chk("midrst_flag_c", 32'(flag_c), 32'(0));
    chk("midrst_flag_z", 32'(flag_z), 32'(0));
    chk("midrst_op_ready", 32'(op_ready), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_res_valid", 32'(res_valid), 32'(0));
    sb.delete();
    m_c = 1'b0;
    m_r = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(T_ADD, 4'd1, 4'd1);   // 2
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
